// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-to-SDRAM arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST,
    RELEASE
  } state_e;

  localparam int unsigned CACHE_BURST_LEN = 4;
  localparam int unsigned SDRAM_ADDR_W    = 32;
  localparam int unsigned DATA_W          = 16;

  // Read bursts always start on an 8-byte (4-word) boundary; writes keep the full address.
  function automatic logic [SDRAM_ADDR_W-1:0] req_addr(input logic [SDRAM_ADDR_W-1:0] addr,
                                                       input logic                    rw);
    return rw ? {addr[SDRAM_ADDR_W-1:3], 3'b000} : addr;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; the port that was not granted last wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/cache_sdram_arbiter.sv
// Shares one SDRAM controller port between the instruction cache (port 0) and data cache (port 1).
module cache_sdram_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned BURST_LEN  = CACHE_BURST_LEN,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    c0_req,
  input  logic [SDRAM_ADDR_W-1:0] c0_addr,
  input  logic                    c0_rw,
  input  logic [DATA_W-1:0]       c0_wdata,
  output logic                    c0_fill,
  output logic                    c0_wack,
  input  logic                    c1_req,
  input  logic [SDRAM_ADDR_W-1:0] c1_addr,
  input  logic                    c1_rw,
  input  logic [DATA_W-1:0]       c1_wdata,
  output logic                    c1_fill,
  output logic                    c1_wack,
  output logic [DATA_W-1:0]       rdata,
  output logic [1:0]              grant,
  output logic                    timeout_err,
  output logic                    sdram_req,
  output logic [SDRAM_ADDR_W-1:0] sdram_addr,
  output logic                    sdram_rw,
  output logic [DATA_W-1:0]       sdram_wdata,
  input  logic                    sdram_fill,
  input  logic                    sdram_wack,
  input  logic [DATA_W-1:0]       sdram_rdata
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WdW   = $clog2(TIMEOUT + 1);
  localparam int unsigned TaW   = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  state_e                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    req_q, req_d;
  logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic [WdW-1:0]          wd_q, wd_d;
  logic [TaW-1:0]          ta_q, ta_d;
  logic                    terr_q, terr_d;

  logic       arb_en;
  logic [1:0] arb_grant;
  logic       in_req;

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({c1_req, c0_req}),
    .en      (arb_en),
    .grant   (arb_grant)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    wd_d    = wd_q;
    ta_d    = ta_q;
    terr_d  = 1'b0;
    arb_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        if (arb_grant != 2'b00) begin
          grant_d = arb_grant;
          req_d   = 1'b1;
          wd_d    = '0;
          state_d = REQ;
          if (arb_grant[1]) begin
            rw_d    = c1_rw;
            addr_d  = req_addr(c1_addr, c1_rw);
            wdata_d = c1_wdata;
          end else begin
            rw_d    = c0_rw;
            addr_d  = req_addr(c0_addr, c0_rw);
            wdata_d = c0_wdata;
          end
        end
      end

      REQ: begin
        // A response of the wrong kind for the current direction is ignored.
        if (rw_q && sdram_fill) begin
          req_d = 1'b0;
          if (BURST_LEN > 1) begin
            beat_d  = BeatW'(1);
            state_d = BURST;
          end else begin
            grant_d = 2'b00;
            ta_d    = '0;
            state_d = RELEASE;
          end
        end else if (!rw_q && sdram_wack) begin
          req_d   = 1'b0;
          grant_d = 2'b00;
          ta_d    = '0;
          state_d = RELEASE;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          wd_d    = WdW'(TIMEOUT);
          terr_d  = 1'b1;
          grant_d = 2'b00;
          ta_d    = '0;
          state_d = RELEASE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      BURST: begin
        // Grant stays with the owner so the tail words on rdata are attributable.
        if (beat_q == BeatW'(BURST_LEN - 1)) begin
          grant_d = 2'b00;
          ta_d    = '0;
          state_d = RELEASE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      RELEASE: begin
        if (ta_q == TaW'(TURNAROUND - 1)) begin
          state_d = IDLE;
        end else begin
          ta_d = ta_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      req_q   <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      beat_q  <= '0;
      wd_q    <= '0;
      ta_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      wd_q    <= wd_d;
      ta_q    <= ta_d;
      terr_q  <= terr_d;
    end
  end

  assign in_req = (state_q == REQ);

  assign c0_fill = sdram_fill & grant_q[0] & in_req & rw_q;
  assign c1_fill = sdram_fill & grant_q[1] & in_req & rw_q;
  assign c0_wack = sdram_wack & grant_q[0] & in_req & ~rw_q;
  assign c1_wack = sdram_wack & grant_q[1] & in_req & ~rw_q;

  assign rdata       = sdram_rdata;
  assign grant       = grant_q;
  assign timeout_err = terr_q;
  assign sdram_req   = req_q;
  assign sdram_addr  = addr_q;
  assign sdram_rw    = rw_q;
  assign sdram_wdata = wdata_q;

endmodule

// File: tb/tb_cache_sdram_arbiter.sv
// Directed bench for cache_sdram_arbiter with a transaction-level reference model.
module tb_cache_sdram_arbiter;

  localparam int BL  = 4;
  localparam int TO  = 8;
  localparam int TA  = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        c0_req = 1'b0, c1_req = 1'b0;
  logic [31:0] c0_addr = '0, c1_addr = '0;
  logic        c0_rw = 1'b1, c1_rw = 1'b1;
  logic [15:0] c0_wdata = '0, c1_wdata = '0;
  logic        c0_fill, c1_fill, c0_wack, c1_wack;
  logic [15:0] rdata;
  logic [1:0]  grant;
  logic        timeout_err, sdram_req, sdram_rw;
  logic [31:0] sdram_addr;
  logic [15:0] sdram_wdata;
  logic        sdram_fill = 1'b0, sdram_wack = 1'b0;
  logic [15:0] sdram_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  cache_sdram_arbiter #(
    .BURST_LEN  (BL),
    .TIMEOUT    (TO),
    .TURNAROUND (TA)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .c0_req      (c0_req),
    .c0_addr     (c0_addr),
    .c0_rw       (c0_rw),
    .c0_wdata    (c0_wdata),
    .c0_fill     (c0_fill),
    .c0_wack     (c0_wack),
    .c1_req      (c1_req),
    .c1_addr     (c1_addr),
    .c1_rw       (c1_rw),
    .c1_wdata    (c1_wdata),
    .c1_fill     (c1_fill),
    .c1_wack     (c1_wack),
    .rdata       (rdata),
    .grant       (grant),
    .timeout_err (timeout_err),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_rw    (sdram_rw),
    .sdram_wdata (sdram_wdata),
    .sdram_fill  (sdram_fill),
    .sdram_wack  (sdram_wack),
    .sdram_rdata (sdram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one owner at a time, with countdowns for burst words and idle gap.
  int          m_owner = -1;
  int          m_last  = 1;
  int          m_wait  = 0;
  int          m_words = 0;
  int          m_gap   = 0;
  logic        m_req   = 1'b0;
  logic        m_terr  = 1'b0;
  logic        m_rw    = 1'b1;
  logic [31:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;

  function automatic int pick(input logic r0, input logic r1, input int last);
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1; m_last <= 1; m_wait <= 0; m_words <= 0; m_gap <= 0;
      m_req <= 1'b0; m_terr <= 1'b0; m_rw <= 1'b1; m_addr <= '0; m_wdata <= '0;
    end else begin
      m_terr <= 1'b0;
      if (m_gap > 0) begin
        m_gap <= m_gap - 1;
      end else if (m_owner >= 0 && m_words > 0) begin
        m_words <= m_words - 1;
        if (m_words == 1) begin m_owner <= -1; m_gap <= TA; end
      end else if (m_owner >= 0) begin
        if (m_rw && sdram_fill) begin
          m_req <= 1'b0; m_words <= BL - 1;
        end else if (!m_rw && sdram_wack) begin
          m_req <= 1'b0; m_owner <= -1; m_gap <= TA;
        end else if (m_wait + 1 == TO) begin
          m_req <= 1'b0; m_terr <= 1'b1; m_owner <= -1; m_gap <= TA;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else begin
        int w;
        w = pick(c0_req, c1_req, m_last);
        if (w == 0) begin
          m_owner <= 0; m_last <= 0; m_req <= 1'b1; m_wait <= 0; m_rw <= c0_rw;
          m_addr <= c0_rw ? (c0_addr & 32'hFFFF_FFF8) : c0_addr; m_wdata <= c0_wdata;
        end else if (w == 1) begin
          m_owner <= 1; m_last <= 1; m_req <= 1'b1; m_wait <= 0; m_rw <= c1_rw;
          m_addr <= c1_rw ? (c1_addr & 32'hFFFF_FFF8) : c1_addr; m_wdata <= c1_wdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] eg;
    logic       asking;
    eg     = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    asking = (m_owner >= 0) && (m_words == 0);
    check("m_grant",       {30'b0, grant},       {30'b0, eg});
    check("m_sdram_req",   {31'b0, sdram_req},   {31'b0, m_req});
    check("m_sdram_addr",  sdram_addr,           m_addr);
    check("m_sdram_rw",    {31'b0, sdram_rw},    {31'b0, m_rw});
    check("m_sdram_wdata", {16'b0, sdram_wdata}, {16'b0, m_wdata});
    check("m_timeout_err", {31'b0, timeout_err}, {31'b0, m_terr});
    check("m_c0_fill", {31'b0, c0_fill}, {31'b0, asking && m_owner == 0 && m_rw && sdram_fill});
    check("m_c1_fill", {31'b0, c1_fill}, {31'b0, asking && m_owner == 1 && m_rw && sdram_fill});
    check("m_c0_wack", {31'b0, c0_wack}, {31'b0, asking && m_owner == 0 && !m_rw && sdram_wack});
    check("m_c1_wack", {31'b0, c1_wack}, {31'b0, asking && m_owner == 1 && !m_rw && sdram_wack});
    check("m_rdata",   {16'b0, rdata},   {16'b0, sdram_rdata});
  end

  int f0_cnt = 0, f1_cnt = 0, w0_cnt = 0, w1_cnt = 0, te_cnt = 0;
  always @(negedge clk) begin
    f0_cnt <= f0_cnt + int'(c0_fill);
    f1_cnt <= f1_cnt + int'(c1_fill);
    w0_cnt <= w0_cnt + int'(c0_wack);
    w1_cnt <= w1_cnt + int'(c1_wack);
    te_cnt <= te_cnt + int'(timeout_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    c0_req = 1'b0; c1_req = 1'b0; sdram_fill = 1'b0; sdram_wack = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (sdram_req === 1'b1) ok = 1'b1;
      else tick();
    end
    check("wait_sdram_req", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int s0, s1;
    logic [1:0] order [4];

    // Reset values
    tick();
    check("rst_grant", {30'b0, grant}, 32'd0);
    check("rst_sdram_req", {31'b0, sdram_req}, 32'd0);
    check("rst_sdram_rw", {31'b0, sdram_rw}, 32'd1);
    check("rst_sdram_addr", sdram_addr, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    do_reset();

    // c0 read at 0x1234, fill on the 5th REQ cycle
    s0 = f0_cnt; s1 = f1_cnt;
    c0_req = 1'b1; c0_rw = 1'b1; c0_addr = 32'h0000_1234;
    tick();
    check("t1_addr", sdram_addr, 32'h0000_1230);
    check("t1_rw", {31'b0, sdram_rw}, 32'd1);
    check("t1_grant", {30'b0, grant}, 32'd1);
    repeat (4) tick();
    sdram_fill = 1'b1; sdram_rdata = 16'h00A0; c0_req = 1'b0;
    #1 check("t1_c0_fill", {31'b0, c0_fill}, 32'd1);
    for (int b = 1; b < BL; b++) begin
      tick();
      sdram_fill = 1'b0; sdram_rdata = 16'h00A0 + 16'(b);
      #1 check("t1_burst_grant", {30'b0, grant}, 32'd1);
      check("t1_rdata", {16'b0, rdata}, 32'h00A0 + b);
    end
    tick();
    check("t1_release_grant", {30'b0, grant}, 32'd0);
    tick();
    check("t1_fill_pulses", f0_cnt - s0, 32'd1);
    check("t1_c1_fill_none", f1_cnt - s1, 32'd0);

    // Both reading continuously from reset: grants alternate
    do_reset();
    c0_req = 1'b1; c0_rw = 1'b1; c0_addr = 32'h0000_2000;
    c1_req = 1'b1; c1_rw = 1'b1; c1_addr = 32'h0000_300C;
    for (int t = 0; t < 4; t++) begin
      wait_req();
      order[t] = grant;
      tick(); tick();
      sdram_fill = 1'b1; sdram_rdata = 16'h0C00 + 16'(t);
      if (t == 3) begin c0_req = 1'b0; c1_req = 1'b0; end
      tick();
      sdram_fill = 1'b0;
      for (int b = 1; b < BL; b++) begin
        check("t2_burst_hold", {30'b0, grant}, {30'b0, order[t]});
        tick();
      end
    end
    check("t2_order0", {30'b0, order[0]}, 32'd1);
    check("t2_order1", {30'b0, order[1]}, 32'd2);
    check("t2_order2", {30'b0, order[2]}, 32'd1);
    check("t2_order3", {30'b0, order[3]}, 32'd2);
    tick(); tick();

    // c1 write 0xBEEF to 0x100, stray fill ignored, wack on 3rd REQ cycle
    s0 = w0_cnt; s1 = w1_cnt;
    c1_req = 1'b1; c1_rw = 1'b0; c1_addr = 32'h0000_0100; c1_wdata = 16'hBEEF;
    tick();
    check("t3_rw", {31'b0, sdram_rw}, 32'd0);
    check("t3_wdata", {16'b0, sdram_wdata}, 32'h0000_BEEF);
    check("t3_addr", sdram_addr, 32'h0000_0100);
    tick();
    sdram_fill = 1'b1;
    #1 check("t3_stray_fill", {31'b0, c1_fill}, 32'd0);
    tick();
    sdram_fill = 1'b0; sdram_wack = 1'b1; c1_req = 1'b0;
    #1 check("t3_c1_wack", {31'b0, c1_wack}, 32'd1);
    check("t3_c0_wack", {31'b0, c0_wack}, 32'd0);
    tick();
    sdram_wack = 1'b0;
    check("t3_req_fall", {31'b0, sdram_req}, 32'd0);
    check("t3_grant_rel", {30'b0, grant}, 32'd0);
    tick();
    check("t3_wack_pulses", w1_cnt - s1, 32'd1);
    check("t3_c0_wack_none", w0_cnt - s0, 32'd0);

    // c0 read with no fill: watchdog after 8 REQ cycles, then pending c1
    s0 = te_cnt;
    c0_req = 1'b1; c0_rw = 1'b1; c0_addr = 32'h0000_0040;
    tick();
    c0_req = 1'b0; c1_req = 1'b1; c1_rw = 1'b1; c1_addr = 32'h0000_0088;
    repeat (7) tick();
    check("t4_req_cycle8", {31'b0, sdram_req}, 32'd1);
    tick();
    check("t4_req_fall", {31'b0, sdram_req}, 32'd0);
    check("t4_terr", {31'b0, timeout_err}, 32'd1);
    tick();
    check("t4_terr_once", {31'b0, timeout_err}, 32'd0);
    tick();
    check("t4_c1_grant", {30'b0, grant}, 32'd2);
    check("t4_c1_addr", sdram_addr, 32'h0000_0088);
    sdram_fill = 1'b1; c1_req = 1'b0;
    tick();
    sdram_fill = 1'b0;
    repeat (4) tick();
    check("t4_terr_pulses", te_cnt - s0, 32'd1);

    // Reset during 2nd burst beat, then c1-only read
    c0_req = 1'b1; c0_rw = 1'b1; c0_addr = 32'h0000_0500;
    tick();
    sdram_fill = 1'b1; sdram_rdata = 16'h00B0; c0_req = 1'b0;
    tick();
    sdram_fill = 1'b0; sdram_rdata = 16'h00B1;
    s0 = f0_cnt;
    reset_n = 1'b0;
    #1 check("t5_grant", {30'b0, grant}, 32'd0);
    check("t5_req", {31'b0, sdram_req}, 32'd0);
    check("t5_addr", sdram_addr, 32'd0);
    check("t5_rw", {31'b0, sdram_rw}, 32'd1);
    check("t5_wdata", {16'b0, sdram_wdata}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    c1_req = 1'b1; c1_rw = 1'b1; c1_addr = 32'h0000_0600;
    tick();
    check("t5_c1_grant", {30'b0, grant}, 32'd2);
    sdram_fill = 1'b1; c1_req = 1'b0;
    #1 check("t5_c1_fill", {31'b0, c1_fill}, 32'd1);
    check("t5_c0_fill", {31'b0, c0_fill}, 32'd0);
    tick();
    sdram_fill = 1'b0;
    repeat (4) tick();
    check("t5_no_stale_fill", f0_cnt - s0, 32'd0);

    // c1 drops req in REQ; fill still routed and burst completes
    s1 = f1_cnt;
    c1_req = 1'b1; c1_rw = 1'b1; c1_addr = 32'h0000_0700;
    tick();
    c1_req = 1'b0;
    tick(); tick();
    sdram_fill = 1'b1;
    #1 check("t6_c1_fill", {31'b0, c1_fill}, 32'd1);
    tick();
    sdram_fill = 1'b0;
    check("t6_burst_grant", {30'b0, grant}, 32'd2);
    repeat (3) tick();
    check("t6_grant_rel", {30'b0, grant}, 32'd0);
    tick();
    check("t6_idle_grant", {30'b0, grant}, 32'd0);
    check("t6_fill_pulses", f1_cnt - s1, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
